// File: rtl/ram_ring_ctrl.sv
// Multi-channel ring-buffer address/strobe generator for an external dual-port RAM.
// Each channel owns an equal slice of the RAM; supports drop-on-full or overwrite-oldest.
module ram_ring_ctrl #(
    parameter int unsigned pW  = 36,
    parameter int unsigned pA  = 18,
    parameter int unsigned pCH = 4,
    localparam int unsigned pCW = (pCH > 1) ? $clog2(pCH) : 1
) (
    input  logic           iclk,
    input  logic           irst,
    input  logic           iclk_ena,
    input  logic           imode,
    input  logic [pCH-1:0] iclr,
    input  logic           iena,
    input  logic [pCW-1:0] ich,
    input  logic [pW-1:0]  idat,
    input  logic           ird,
    input  logic [pCW-1:0] ird_ch,
    output logic           owrena,
    output logic [pA-1:0]  owr_adr,
    output logic [pW-1:0]  odat,
    output logic           ordena,
    output logic [pA-1:0]  ord_adr,
    output logic [pCH-1:0] ofull,
    output logic [pCH-1:0] oempty,
    output logic [pCH-1:0] oovf,
    output logic [pCH-1:0] ounf
);

    localparam int unsigned CHB = $clog2(pCH);
    localparam int unsigned PW  = pA - CHB;
    localparam int unsigned CW  = PW + 1;
    localparam logic [CW-1:0] DEPTH = {1'b1, {PW{1'b0}}};

    logic [PW-1:0]  wptr_q [pCH];
    logic [PW-1:0]  wptr_d [pCH];
    logic [PW-1:0]  rptr_q [pCH];
    logic [PW-1:0]  rptr_d [pCH];
    logic [CW-1:0]  cnt_q  [pCH];
    logic [CW-1:0]  cnt_d  [pCH];
    logic [pCH-1:0] ovf_q, ovf_d, unf_q, unf_d, full_q, full_d, empty_q, empty_d;
    logic           wr_q, wr_d, rd_q, rd_d;
    logic [pA-1:0]  wadr_q, wadr_d, radr_q, radr_d;
    logic [pW-1:0]  dat_q, dat_d;

    logic [pCW-1:0] wc, rc;
    logic [pA-1:0]  wadr_new, radr_new;
    logic           w_full, r_empty, w_live, r_live, wr_acc, rd_acc;

    // With a single channel the channel selects carry no information.
    assign wc = (pCH == 1) ? '0 : ich;
    assign rc = (pCH == 1) ? '0 : ird_ch;

    if (pCH == 1) begin : g_single
        assign wadr_new = wptr_q[wc];
        assign radr_new = rptr_q[rc];
    end else begin : g_multi
        assign wadr_new = {wc, wptr_q[wc]};
        assign radr_new = {rc, rptr_q[rc]};
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        wadr_d  = wadr_q;
        radr_d  = radr_q;
        dat_d   = dat_q;
        full_d  = full_q;
        empty_d = empty_q;

        // Accept decisions look only at the state at the start of the cycle.
        w_full  = (cnt_q[wc] == DEPTH);
        r_empty = (cnt_q[rc] == '0);
        w_live  = iclk_ena && iena && !iclr[wc];
        r_live  = iclk_ena && ird && !iclr[rc];
        wr_acc  = w_live && (!w_full || imode);
        rd_acc  = r_live && !r_empty;

        if (wr_acc) begin
            wr_d   = 1'b1;
            wadr_d = wadr_new;
            dat_d  = idat;
        end
        if (rd_acc) begin
            rd_d   = 1'b1;
            radr_d = radr_new;
        end

        for (int c = 0; c < pCH; c++) begin
            if (wr_acc && wc == pCW'(c)) begin
                wptr_d[c] = wptr_q[c] + PW'(1);
            end
            if (wr_acc && wc == pCW'(c) && w_full) begin
                // Overwrite pushes out the oldest word; a same-cycle read consumes that same word.
                rptr_d[c] = rptr_q[c] + PW'(1);
            end else begin
                if (rd_acc && rc == pCW'(c)) begin
                    rptr_d[c] = rptr_q[c] + PW'(1);
                end
                unique case ({wr_acc && wc == pCW'(c), rd_acc && rc == pCW'(c)})
                    2'b10:   cnt_d[c] = cnt_q[c] + CW'(1);
                    2'b01:   cnt_d[c] = cnt_q[c] - CW'(1);
                    default: cnt_d[c] = cnt_q[c];
                endcase
            end
            if (w_live && w_full && wc == pCW'(c)) ovf_d[c] = 1'b1;
            if (r_live && r_empty && rc == pCW'(c)) unf_d[c] = 1'b1;
            if (iclk_ena && iclr[c]) begin
                wptr_d[c] = '0;
                rptr_d[c] = '0;
                cnt_d[c]  = '0;
                ovf_d[c]  = 1'b0;
                unf_d[c]  = 1'b0;
            end
            full_d[c]  = (cnt_d[c] == DEPTH);
            empty_d[c] = (cnt_d[c] == '0);
        end
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            for (int c = 0; c < pCH; c++) begin
                wptr_q[c] <= '0;
                rptr_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            ovf_q   <= '0;
            unf_q   <= '0;
            full_q  <= '0;
            empty_q <= '1;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            wadr_q  <= '0;
            radr_q  <= '0;
            dat_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            wadr_q  <= wadr_d;
            radr_q  <= radr_d;
            dat_q   <= dat_d;
        end
    end

    assign owrena  = wr_q;
    assign owr_adr = wadr_q;
    assign odat    = dat_q;
    assign ordena  = rd_q;
    assign ord_adr = radr_q;
    assign ofull   = full_q;
    assign oempty  = empty_q;
    assign oovf    = ovf_q;
    assign ounf    = unf_q;

endmodule

// File: doc/ram_ring_ctrl.md
Name: ram_ring_ctrl

Overview:
- Multi-channel circular-buffer address/enable generator for an external simple dual-port RAM of 2**pA words by pW bits.
- The RAM is split into pCH equal regions, one ring buffer per channel.
- Accepts a tagged write stream and tagged read requests. Issues registered RAM write/read strobes, addresses and write data.
- Keeps per-channel full/empty/overflow/underflow status and supports a drop-on-full (FIFO) mode or an overwrite-oldest (ring) mode.

Parameters:
pW, 36, data width
pA, 18, total RAM address width
pCH, 4, channel count; power of 2, 1..2**(pA-1); pCW = max(1,clog2(pCH)); per-channel depth D = 2**(pA-clog2(pCH))

Ports:
iclk  input  1  clock, rising edge
irst  input  1  reset, asynchronous, active-low
iclk_ena  input  1  clock enable; all state advances only when 1
imode  input  1  0 = FIFO (drop on full), 1 = ring (overwrite oldest); sampled per cycle
iclr  input  pCH  per-channel synchronous flush
iena  input  1  write request
ich  input  pCW  write channel
idat  input  pW  write data
ird  input  1  read request
ird_ch  input  pCW  read channel
owrena  output  1  RAM write strobe
owr_adr  output  pA  RAM write address = {ich, wptr}
odat  output  pW  RAM write data
ordena  output  1  RAM read strobe
ord_adr  output  pA  RAM read address = {ird_ch, rptr}
ofull  output  pCH  channel count == D
oempty  output  pCH  channel count == 0
oovf  output  pCH  sticky overflow
ounf  output  pCH  sticky underflow

Behaviour:
- Reset (irst=0, asynchronous):
  - all wptr/rptr/count, owrena, ordena, owr_adr, ord_adr, odat, ofull, oovf and ounf = 0; oempty = all 1.
  - Applies mid-transfer: any pending strobe is cleared immediately.
- Per channel: wptr and rptr are clog2(D) bits and wrap modulo D. Count is clog2(D)+1 bits.
- ofull and oempty are registered and reflect the count after the cycle's update.
- Latency: request accepted in cycle N gives strobe/address/data valid in cycle N+1, each for exactly one cycle.
- iclk_ena=0:
  - no request accepted; owrena and ordena are 0 in the following cycle.
  - pointers, counts, flags, addresses and odat hold.
- Accept decisions use the channel state at the start of the cycle.
- Write (iena=1, iclk_ena=1, channel c=ich):
  - not full: accept; owrena=1, owr_adr={c,wptr[c]}, odat=idat; wptr[c]++, count[c]++.
  - full, imode=0: drop; owrena=0, oovf[c] set, state unchanged.
  - full, imode=1: accept as above and additionally rptr[c]++; count stays D; oovf[c] set.
- Read (ird=1, iclk_ena=1, channel r=ird_ch):
  - not empty: ordena=1, ord_adr={r,rptr[r]}; rptr[r]++, count[r]--.
  - empty: ignored, ounf[r] set. There is no write-to-read bypass.
- Simultaneous write and read on the same channel:
  - neither full nor empty: both accepted, count unchanged.
  - empty: write accepted, read rejected (ounf set), count goes to 1.
  - full, imode=0: read accepted, write dropped (oovf set), count goes to D-1.
  - full, imode=1: both accepted; rptr advances once only; count stays D; ord_adr is the pre-cycle rptr.
- Different channels: write and read are fully independent.
- iclr[c]=1 with iclk_ena=1:
  - zeroes wptr/rptr/count/oovf/ounf of channel c.
  - has priority over any write or read to c in the same cycle; those requests are discarded without setting flags and give no strobe.
- pCH=1: ich/ird_ch are ignored; addresses are the pointer only (no channel field).

Test Plan (pCH=4, pA=6, D=16, pW=8):
- Reset, then write ch2 data 0x11,0x22,0x33 -> owr_adr 0x20,0x21,0x22 one cycle after each request, odat matches; then read ch2 x3 -> ord_adr 0x20,0x21,0x22, oempty[2] returns to 1.
- FIFO mode: write 17 words to ch1 -> ofull[1]=1 after the 16th; 17th gives no owrena and oovf[1]=1; next write lands at 0x10 only after one read.
- Ring mode: write 20 words to ch0 -> all 20 strobed, last at adr 0x03; rptr=4; next read gives ord_adr 0x04; ofull[0] stays 1.
- Empty ch3: write and read in the same cycle -> owrena=1 at 0x30, ordena=0, ounf[3]=1. Next cycle a read gives ord_adr 0x30.
- iclk_ena toggled 1,0,1 during a continuous write on ch1 -> exactly two strobes; addresses consecutive with no skip.
- iclr[1] asserted with a write to ch1, and irst pulsed low mid-stream -> no strobe, ch1 empty and flags clear; after reset owrena/ordena=0 and oempty=4'b1111 immediately.
